// File: rtl/hack_memory.sv
// Hack computer data-memory map: 16K word RAM, memory-mapped screen port
// (registered write, combinational read) and a small key-event FIFO with a
// status word. All reads are combinational from addressM.
module hack_memory #(
  parameter int KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic        scr_we,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic [15:0] scr_rdata,
  output logic [12:0] scr_raddr,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic        kbd_overflow
);

  // Pointer width; depth is a power of two so natural pointer overflow
  // gives the modulo-KBD_DEPTH wrap.
  localparam int PW = $clog2(KBD_DEPTH);
  localparam logic [4:0] DEPTH5 = 5'(KBD_DEPTH);

  localparam logic [14:0] KBD_ADDR = 15'h6000;
  localparam logic [14:0] STS_ADDR = 15'h6001;

  // Address decode
  logic ram_sel, scr_sel, kbd_sel, sts_sel;
  assign ram_sel = ~addressM[14];
  assign scr_sel = (addressM[14:13] == 2'b10);
  assign kbd_sel = (addressM == KBD_ADDR);
  assign sts_sel = (addressM == STS_ADDR);

  // ---------------------------------------------------------------- RAM
  logic [15:0] ram_q [0:16383];

  // RAM write port; contents intentionally survive reset, writes are
  // blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && writeM && ram_sel)
      ram_q[addressM[13:0]] <= outM;
  end

  // ------------------------------------------------------------- SCREEN
  logic        scr_we_q,   scr_we_d;
  logic [12:0] scr_addr_q, scr_addr_d;
  logic [15:0] scr_data_q, scr_data_d;

  // Screen write request for the next cycle; address/data hold otherwise.
  always_comb begin
    scr_we_d   = writeM & scr_sel;
    scr_addr_d = scr_addr_q;
    scr_data_d = scr_data_q;
    if (writeM && scr_sel) begin
      scr_addr_d = addressM[12:0];
      scr_data_d = outM;
    end
  end

  // Screen port registers; a reset before the strobe cycle drops the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scr_we_q   <= 1'b0;
      scr_addr_q <= '0;
      scr_data_q <= '0;
    end else begin
      scr_we_q   <= scr_we_d;
      scr_addr_q <= scr_addr_d;
      scr_data_q <= scr_data_d;
    end
  end

  assign scr_we    = scr_we_q;
  assign scr_addr  = scr_addr_q;
  assign scr_data  = scr_data_q;
  assign scr_raddr = addressM[12:0];

  // ----------------------------------------------------------- KEY FIFO
  logic [15:0]   kbd_mem_q [0:KBD_DEPTH-1];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]    count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          push, pop, ovf_evt;

  assign kbd_ready = (count_q < DEPTH5);
  assign push      = kbd_valid & kbd_ready;
  assign ovf_evt   = kbd_valid & ~kbd_ready;
  assign pop       = writeM & kbd_sel & (count_q != 5'd0);

  // FIFO bookkeeping: push/pop pointers, occupancy and sticky overflow.
  // Overflow set takes priority over a same-cycle clear.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (ovf_evt)
      ovf_d = 1'b1;
    else if (writeM && sts_sel)
      ovf_d = 1'b0;
  end

  // FIFO control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; entries need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push)
      kbd_mem_q[wr_ptr_q] <= kbd_code;
  end

  assign kbd_overflow = ovf_q;

  // --------------------------------------------------------- READ MUX
  // Zero-latency read path; unmapped space reads as zero.
  always_comb begin
    inM = 16'h0000;
    if (ram_sel)
      inM = ram_q[addressM[13:0]];
    else if (scr_sel)
      inM = scr_rdata;
    else if (kbd_sel)
      inM = (count_q != 5'd0) ? kbd_mem_q[rd_ptr_q] : 16'h0000;
    else if (sts_sel)
      inM = {ovf_q, 10'b0, count_q};
  end

endmodule

// File: tb/tb_hack_memory.sv
// Self-checking bench for hack_memory: directed scenarios plus random
// traffic, compared against a queue/array reference model.
module tb_hack_memory;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        scr_we;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic [15:0] scr_rdata;
  logic [12:0] scr_raddr;
  logic [15:0] kbd_code;
  logic        kbd_valid;
  logic        kbd_ready;
  logic        kbd_overflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Framebuffer stand-in: read data is a fixed function of the address.
  function automatic logic [15:0] sfun(input logic [12:0] a);
    return {3'b110, a} ^ 16'h5A5A;
  endfunction
  assign scr_rdata = sfun(scr_raddr);

  hack_memory #(.KBD_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM),
    .writeM(writeM), .inM(inM), .scr_we(scr_we), .scr_addr(scr_addr),
    .scr_data(scr_data), .scr_rdata(scr_rdata), .scr_raddr(scr_raddr),
    .kbd_code(kbd_code), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow)
  );

  // Reference model state
  logic [15:0] ram_m   [0:16383];
  bit          known_m [0:16383];
  logic [15:0] kq [$];
  logic        ovf_m;
  logic        swe_m;
  logic [12:0] sa_m;
  logic [15:0] sd_m;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    ovf_m = 1'b0;
    swe_m = 1'b0;
    sa_m  = '0;
    sd_m  = '0;
  endtask

  function automatic logic [15:0] model_read(input logic [14:0] a, output bit ok);
    ok = 1'b1;
    if (a < 15'h4000) begin
      ok = known_m[a[13:0]];
      return ram_m[a[13:0]];
    end
    if (a < 15'h6000) return sfun(a[12:0]);
    if (a == 15'h6000) return (kq.size() > 0) ? kq[0] : 16'h0000;
    if (a == 15'h6001) return {ovf_m, 10'b0, 5'(kq.size())};
    return 16'h0000;
  endfunction

  // One bus cycle: drive inputs just after a rising edge, check at the
  // falling edge, then advance the model across the next rising edge.
  task automatic cycle(input logic rst, input logic [14:0] a, input logic [15:0] d,
                       input logic we, input logic kv, input logic [15:0] kc,
                       input logic cc, input logic [15:0] cv);
    bit ok;
    logic [15:0] e;
    bit full, pop, push;
    reset = rst; addressM = a; outM = d; writeM = we;
    kbd_valid = kv; kbd_code = kc;
    if (rst) model_reset();
    @(negedge clk);
    e = model_read(a, ok);
    if (ok) chk("inM", inM, e);
    if (cc) chk("inM_directed", inM, cv);
    chk("kbd_ready", 16'(kbd_ready), 16'(kq.size() < D));
    chk("kbd_overflow", 16'(kbd_overflow), 16'(ovf_m));
    chk("scr_we", 16'(scr_we), 16'(swe_m));
    chk("scr_addr", 16'(scr_addr), 16'(sa_m));
    chk("scr_data", scr_data, sd_m);
    chk("scr_raddr", 16'(scr_raddr), 16'(a[12:0]));
    @(posedge clk);
    #1;
    if (!rst) begin
      full  = (kq.size() == D);
      swe_m = we && (a[14:13] == 2'b10);
      if (swe_m) begin sa_m = a[12:0]; sd_m = d; end
      if (we && a < 15'h4000) begin
        ram_m[a[13:0]] = d;
        known_m[a[13:0]] = 1'b1;
      end
      pop  = we && (a == 15'h6000) && (kq.size() > 0);
      push = kv && !full;
      if (pop)  void'(kq.pop_front());
      if (push) kq.push_back(kc);
      if (kv && full) ovf_m = 1'b1;
      else if (we && a == 15'h6001) ovf_m = 1'b0;
    end
  endtask

  task automatic rd(input logic [14:0] a, input logic [15:0] cv);
    cycle(1'b0, a, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, cv);
  endtask
  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    cycle(1'b0, a, d, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask
  task automatic key(input logic [15:0] c);
    cycle(1'b0, 15'h7000, 16'h0, 1'b0, 1'b1, c, 1'b0, 16'h0);
  endtask

  initial begin
    logic [14:0] a;
    logic [15:0] d;
    logic we, kv;
    for (int i = 0; i < 16384; i++) known_m[i] = 1'b0;
    reset = 1'b1; addressM = '0; outM = '0; writeM = 1'b0;
    kbd_valid = 1'b0; kbd_code = '0;
    model_reset();
    @(posedge clk); #1;
    // Reset state, with write attempts that must be ignored
    cycle(1'b1, 15'h6001, 16'h0, 1'b0, 1'b1, 16'h0077, 1'b1, 16'h0000);
    cycle(1'b1, 15'h4003, 16'h1111, 1'b1, 1'b1, 16'h0078, 1'b0, 16'h0);
    rd(15'h6001, 16'h0000);
    rd(15'h6000, 16'h0000);

    // RAM write then same-cycle read, neighbour untouched
    wr(15'h0011, 16'hAAAA);
    wr(15'h0010, 16'h1234);
    rd(15'h0010, 16'h1234);
    rd(15'h0011, 16'hAAAA);

    // Screen write strobe one cycle later, then clear
    wr(15'h4005, 16'hFFFF);
    rd(15'h4005, sfun(13'h0005));
    rd(15'h7FFF, 16'h0000);
    wr(15'h7ABC, 16'h5555);
    rd(15'h7ABC, 16'h0000);

    // Basic push / peek / pop
    key(16'h0041);
    key(16'h0042);
    rd(15'h6000, 16'h0041);
    wr(15'h6000, 16'h0);
    rd(15'h6000, 16'h0042);
    rd(15'h6001, 16'h0001);
    wr(15'h6000, 16'h0);
    wr(15'h6000, 16'h0);     // pop when empty: no effect
    rd(15'h6001, 16'h0000);

    // Fill, overflow, clear
    for (int i = 1; i <= 5; i++) key(16'h0100 + 16'(i));
    rd(15'h6001, 16'h8004);
    rd(15'h6000, 16'h0101);
    wr(15'h6001, 16'h0);
    rd(15'h6001, 16'h0004);

    // Full: pop with valid -> no push, overflow set, count 3
    cycle(1'b0, 15'h6000, 16'h0, 1'b1, 1'b1, 16'h01FF, 1'b0, 16'h0);
    rd(15'h6001, 16'h8003);
    // Non-full push+pop: count unchanged, order kept
    cycle(1'b0, 15'h6000, 16'h0, 1'b1, 1'b1, 16'h01AA, 1'b0, 16'h0);
    rd(15'h6001, 16'h8003);
    rd(15'h6000, 16'h0103);
    key(16'h01BB);
    // Clear collides with overflow event: overflow wins
    cycle(1'b0, 15'h6001, 16'h0, 1'b1, 1'b1, 16'h01CC, 1'b0, 16'h0);
    rd(15'h6001, 16'h8004);
    wr(15'h6000, 16'h0);
    rd(15'h6001, 16'h8003);

    // Reset mid-operation; pending screen write and RAM write discarded
    cycle(1'b1, 15'h0010, 16'hDEAD, 1'b1, 1'b1, 16'h0999, 1'b1, 16'h1234);
    cycle(1'b1, 15'h4009, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    rd(15'h6000, 16'h0000);
    rd(15'h6001, 16'h0000);
    rd(15'h0010, 16'h1234);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 15'($urandom_range(0, 31));
        2:    a = 15'($urandom_range(16'h4000, 16'h5FFF));
        3:    a = 15'h6000;
        4:    a = 15'h6001;
        default: a = 15'($urandom_range(16'h6002, 16'h7FFF));
      endcase
      d  = 16'($urandom);
      we = ($urandom_range(0, 9) < 3);
      kv = ($urandom_range(0, 9) < 4);
      cycle(1'b0, a, d, we, kv, 16'($urandom), 1'b0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
